// File: rtl/alu_acc_ctrl_if.sv
// alu_acc_ctrl_if: command and result handshake bundle between a producer/consumer and the ALU sequencer
interface alu_acc_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_pre_zero;
    logic             res_zero;

    modport master (
        output cmd_valid, cmd_op, cmd_data, res_ready,
        input  cmd_ready, res_valid, res_data, res_pre_zero, res_zero
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, res_ready,
        output cmd_ready, res_valid, res_data, res_pre_zero, res_zero
    );
endinterface

// File: rtl/alu_acc_ctrl.sv
// alu_acc_ctrl: one-command-at-a-time sequencer that feeds an external combinational ALU and accumulates its result
module alu_acc_ctrl #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_acc_ctrl_if.slave        bus,
    output logic [2:0]           alu_opcode,
    output logic [WIDTH-1:0]     alu_in_a,
    output logic [WIDTH-1:0]     alu_in_b,
    input  logic                 alu_a_is_zero,
    input  logic [WIDTH-1:0]     alu_out,
    output logic [WIDTH-1:0]     acc,
    output logic [CNT_WIDTH-1:0] done_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state;
    state_t state_next;

    // State register; reset drops any in-flight command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state: accept in IDLE, EXEC lasts exactly one cycle, RESP waits for the consumer
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = bus.cmd_valid ? EXEC : IDLE;
            EXEC:    state_next = RESP;
            RESP:    state_next = bus.res_ready ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs depend on state only, so no combinational path from valid/ready inputs
    always_comb begin
        bus.cmd_ready = (state == IDLE);
        bus.res_valid = (state == RESP);
    end

    assign alu_in_a = acc;

    // Datapath: latch the command on accept, capture the ALU result in EXEC, count consumed results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode       <= '0;
            alu_in_b         <= '0;
            acc              <= '0;
            bus.res_data     <= '0;
            bus.res_pre_zero <= 1'b0;
            bus.res_zero     <= 1'b0;
            done_count       <= '0;
        end else begin
            if (state == IDLE && bus.cmd_valid) begin
                alu_opcode <= bus.cmd_op;
                alu_in_b   <= bus.cmd_data;
            end
            if (state == EXEC) begin
                acc              <= alu_out;
                bus.res_data     <= alu_out;
                bus.res_pre_zero <= alu_a_is_zero;
                bus.res_zero     <= (alu_out == '0);
            end
            if (state == RESP && bus.res_ready)
                done_count <= done_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_alu_acc_ctrl.sv
// tb_alu_acc_ctrl: directed and randomized checks of the ALU sequencer against a transaction-level accumulator model
module tb_alu_acc_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] alu_opcode;
    logic [7:0] alu_in_a;
    logic [7:0] alu_in_b;
    logic       alu_a_is_zero;
    logic [7:0] alu_out;
    logic [7:0] acc;
    logic [7:0] done_count;

    int checks = 0;
    int passed = 0;

    logic [7:0] m_acc = 8'h00;
    logic [7:0] m_count = 8'h00;

    alu_acc_ctrl_if #(.WIDTH(8)) bus ();

    alu_acc_ctrl #(.WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .alu_opcode    (alu_opcode),
        .alu_in_a      (alu_in_a),
        .alu_in_b      (alu_in_b),
        .alu_a_is_zero (alu_a_is_zero),
        .alu_out       (alu_out),
        .acc           (acc),
        .done_count    (done_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd2:    return 8'((int'(a) + int'(b)) % 256);
            3'd3:    return a & b;
            3'd4:    return a ^ b;
            3'd5:    return b;
            default: return a;
        endcase
    endfunction

    always_comb begin
        alu_out       = alu_fn(alu_opcode, alu_in_a, alu_in_b);
        alu_a_is_zero = (alu_in_a == 8'h00);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [7:0] data, input int hold);
        logic [7:0] exp_res;
        logic       exp_pre;
        exp_pre = (m_acc == 8'h00);
        exp_res = alu_fn(op, m_acc, data);
        check("cmd_ready_idle", 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check("exec_cmd_ready", 32'(bus.cmd_ready), 0);
        check("exec_res_valid", 32'(bus.res_valid), 0);
        check("exec_opcode", 32'(alu_opcode), 32'(op));
        check("exec_in_b", 32'(alu_in_b), 32'(data));
        check("exec_in_a", 32'(alu_in_a), 32'(m_acc));
        m_acc = exp_res;
        @(posedge clk); #1;
        check("resp_valid", 32'(bus.res_valid), 1);
        check("resp_data", 32'(bus.res_data), 32'(exp_res));
        check("resp_pre_zero", 32'(bus.res_pre_zero), 32'(exp_pre));
        check("resp_zero", 32'(bus.res_zero), 32'(exp_res == 8'h00));
        check("resp_acc", 32'(acc), 32'(exp_res));
        for (int i = 0; i < hold; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 3'($urandom_range(0, 7));
            bus.cmd_data  = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            check("hold_valid", 32'(bus.res_valid), 1);
            check("hold_data", 32'(bus.res_data), 32'(exp_res));
            check("hold_cmd_ready", 32'(bus.cmd_ready), 0);
            check("hold_acc", 32'(acc), 32'(exp_res));
            check("hold_count", 32'(done_count), 32'(m_count));
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        m_count = m_count + 8'd1;
        check("done_count", 32'(done_count), 32'(m_count));
        check("idle_cmd_ready", 32'(bus.cmd_ready), 1);
        check("idle_res_valid", 32'(bus.res_valid), 0);
        check("idle_opcode_held", 32'(alu_opcode), 32'(op));
        check("idle_in_b_held", 32'(alu_in_b), 32'(data));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        m_acc   = 8'h00;
        m_count = 8'h00;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_res_valid", 32'(bus.res_valid), 0);
        check("rst_acc", 32'(acc), 0);
        check("rst_count", 32'(done_count), 0);
        check("rst_opcode", 32'(alu_opcode), 0);
        check("rst_in_b", 32'(alu_in_b), 0);
        check("rst_res_data", 32'(bus.res_data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_data  = 8'h00;
        bus.res_ready = 1'b0;
        @(posedge clk); #1;
        apply_reset();

        do_cmd(3'd5, 8'h42, 0);
        check("load_acc", 32'(acc), 32'h42);
        do_cmd(3'd2, 8'h86, 0);
        check("add_acc", 32'(acc), 32'hC8);
        do_cmd(3'd4, 8'hC8, 0);
        check("xor_zero", 32'(bus.res_zero), 1);
        do_cmd(3'd7, 8'h55, 0);
        check("pass_pre_zero", 32'(bus.res_pre_zero), 1);

        do_cmd(3'd5, 8'h42, 0);
        do_cmd(3'd3, 8'h86, 0);
        check("and_acc", 32'(acc), 32'h02);
        do_cmd(3'd2, 8'hFF, 0);
        check("add_carry_acc", 32'(acc), 32'h01);

        do_cmd(3'd5, 8'hA5, 5);
        check("bp_acc", 32'(acc), 32'hA5);

        for (int n = 0; n < 40; n++)
            do_cmd(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));

        check("mid_cmd_ready", 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd2;
        bus.cmd_data  = 8'h10;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check("mid_in_exec", 32'(bus.cmd_ready), 0);
        apply_reset();
        check("mid_discard_valid", 32'(bus.res_valid), 0);
        check("mid_discard_acc", 32'(acc), 0);
        do_cmd(3'd5, 8'h33, 0);
        check("post_rst_load", 32'(acc), 32'h33);

        apply_reset();
        for (int n = 0; n < 256; n++)
            do_cmd(3'd5, 8'(n), 0);
        check("wrap_256", 32'(done_count), 0);
        do_cmd(3'd5, 8'h77, 0);
        check("wrap_257", 32'(done_count), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/alu_acc_ctrl.md
# alu_acc_ctrl

Sequencing front-end for the parameterised ALU: it accepts one command at a time (3-bit opcode + operand) over a valid/ready handshake. It drives the ALU's `opcode`/`in_a`/`in_b` from registered state, with `in_a` always the internal accumulator. It captures `alu_out` back into the accumulator and presents the result and flags on a second valid/ready handshake. The ALU remains a separate combinational instance; this block sits directly upstream and downstream of it.

## Interface

- `WIDTH`, 8, datapath width; must match the ALU instance.
- `CNT_WIDTH`, 8, width of the completed-command counter.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in 3: ALU opcode.
  - 0/1/6/7 pass A
  - 2 ADD
  - 3 AND
  - 4 XOR
  - 5 pass B (load)
- `cmd_data` in WIDTH: operand, routed to the ALU B input.
- `alu_opcode` out 3: to ALU `opcode`.
- `alu_in_a` out WIDTH: to ALU `in_a`; always equals `acc`.
- `alu_in_b` out WIDTH: to ALU `in_b`.
- `alu_a_is_zero` in 1: from ALU `a_is_zero`.
- `alu_out` in WIDTH: from ALU `alu_out`.
- `res_valid` out 1: result present.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out WIDTH: result (the new accumulator value).
- `res_pre_zero` out 1: accumulator was zero before the op (sampled `alu_a_is_zero`).
- `res_zero` out 1: `res_data == 0`.
- `acc` out WIDTH: current accumulator.
- `done_count` out CNT_WIDTH: number of results consumed; wraps modulo 2^CNT_WIDTH.

## Operation

- Three-state FSM: IDLE, EXEC, RESP.
- IDLE:
  - `cmd_ready=1`.
  - On `cmd_valid` at a rising edge: `alu_opcode<=cmd_op`, `alu_in_b<=cmd_data`, go to EXEC.
  - Otherwise stay in IDLE.
- EXEC:
  - `cmd_ready=0`, `res_valid=0`. The ALU evaluates combinationally from the registered opcode, `in_b` and `acc`.
  - At the next edge, capture `acc<=alu_out`, `res_data<=alu_out`, `res_pre_zero<=alu_a_is_zero`, `res_zero<=(alu_out==0)`; go to RESP unconditionally.
- RESP:
  - `res_valid=1`, `cmd_ready=0`.
  - On `res_ready` at an edge: `done_count<=done_count+1` (wraps), go to IDLE.
  - Otherwise hold. `res_data`/flags/`acc` are stable while `res_valid=1 && res_ready=0`.
- `cmd_valid` asserted outside IDLE is ignored; no command is queued.
- `alu_opcode`/`alu_in_b` hold their last command's values after the command completes; they change only on acceptance.
- Arithmetic: ADD result truncated to WIDTH bits; carry discarded. No overflow flag.
- Reset (asynchronous, any state, including mid-EXEC or mid-RESP):
  - FSM to IDLE; any in-flight command is discarded and not counted.
  - `acc`, `alu_opcode`, `alu_in_b`, `res_data`, `res_pre_zero`, `res_zero`, `done_count` all go to 0; `res_valid` goes to 0.
  - `cmd_ready` reads 1 while in reset and after reset.

## Timing

- Command accepted at edge E0 → EXEC during the following cycle → `acc`/`res_*` updated and `res_valid=1` after E1.
  - Latency is 2 edges from acceptance to `res_valid`.
- Result consumed at edge E2 (earliest) → IDLE, `cmd_ready=1` after E2. Peak throughput is one command per 3 cycles.
- `cmd_ready` and `res_valid` are decoded from FSM state only, with no combinational path from `cmd_valid`/`res_ready`.
- `alu_in_a` = `acc` combinationally. `alu_a_is_zero` therefore reflects the pre-op accumulator during EXEC.

## Test plan

- Reset, then LOAD: reset, `cmd_op=5` `cmd_data=0x42` → 2 edges later `res_valid=1`, `res_data=0x42`, `res_pre_zero=1`, `res_zero=0`, `acc=0x42`.
- ADD then XOR to zero: ADD `0x86` → `res_data=0xC8`, `res_pre_zero=0`. Then XOR `0xC8` → `res_data=0x00`, `res_zero=1`. Then op 7 with data `0x55` → `res_data=0x00`, `res_pre_zero=1`.
- AND: from `acc=0x42`, `cmd_op=3` `cmd_data=0x86` → `res_data=0x02`. ADD `0xFF` from `acc=0x02` → `res_data=0x01` (carry dropped).
- Backpressure: hold `res_ready=0` for 5 cycles with `cmd_valid=1` → `res_valid` stays 1, `res_data` stable, `cmd_ready=0`, `acc` unchanged. Then `res_ready=1` → IDLE next cycle, `done_count` increments by exactly 1.
- Reset mid-operation: assert `rst_n=0` during EXEC of ADD `0x10` → `acc=0`, `res_valid=0`, `done_count` unchanged (0), `cmd_ready=1` immediately; after release, a LOAD `0x33` completes normally.
- Counter wrap: 256 back-to-back LOAD commands, each result consumed → `done_count` reads 0 after the 256th; a 257th completion reads 1.
